// File: rtl/rx_fifo_buffer.sv
// Receive-side FIFO between the UART receiver and the host: edge-qualified capture with clr_rda ack,
// rd_en pop, occupancy and sticky overflow. Define RX_FIFO_FWFT_EN for first-word fall-through reads.
module rx_fifo_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       receiver_buffer,
    input  logic                   RDA,
    output logic                   clr_rda,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             rda_q;
    logic             wr_evt;
    logic             pop_ok;
    logic             wr_ok;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign wr_evt = RDA & ~rda_q;
    assign pop_ok = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    assign wr_ok  = wr_evt & (~full | pop_ok);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rda_q    <= 1'b0;
            clr_rda  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rda_q   <= RDA;
            clr_rda <= wr_evt;
            if (wr_ok)  wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_evt && !wr_ok) overflow <= 1'b1;
            else if (clr_ovf)     overflow <= 1'b0;
        end
    end

    // NOTE: storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= receiver_buffer;
    end

`ifdef RX_FIFO_FWFT_EN
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule
